// File: rtl/ov7670_cfg_seq.sv
// ov7670_cfg_seq
// Walks a synchronous register ROM of {value, reg_addr} words and turns each
// entry into an SCCB write command. It handles these entry types:
//   16'hFFFF           end of table
//   {n, 8'hFF}         wait n*DELAY_UNIT clocks (n = 0 means no wait)
//   anything else      write value to reg, with NACK retry up to MAX_RETRY
// Optional build macro OV_SOFTRST_WAIT_EN: after a successful COM7 (8'h12)
// write with bit 7 set, the sequencer waits RST_WAIT_CYC clocks for the sensor
// soft reset to settle before moving to the next entry.
module ov7670_cfg_seq #(
  parameter int ADDR_W       = 5,
  parameter int NUM_REGS     = 23,
  parameter int DELAY_UNIT   = 1000,
  parameter int MAX_RETRY    = 3,
  parameter int RST_WAIT_CYC = 100000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [7:0]        cmd_reg,
  output logic [7:0]        cmd_data,
  input  logic              cmd_done,
  input  logic              cmd_nack,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] err_idx
);

  // The delay counter must hold the longest marker delay or the soft-reset
  // settle time, whichever is larger, without wrapping.
  localparam int MARK_CYC = 255 * DELAY_UNIT;
  localparam int MAX_CYC  = (RST_WAIT_CYC > MARK_CYC) ? RST_WAIT_CYC : MARK_CYC;
  localparam int CNT_W    = $clog2(MAX_CYC + 1);
  localparam int RETRY_W  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  // Entry count in one extra bit so NUM_REGS == 2**ADDR_W compares correctly.
  localparam logic [ADDR_W:0] REGS_W = (ADDR_W + 1)'(NUM_REGS);

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_DECODE,
    S_ISSUE,
    S_WAIT_RESP,
    S_DELAY,
    S_NEXT,
    S_DONE,
    S_ERROR
  } state_t;

  state_t             state;
  logic [ADDR_W-1:0]  idx;
  logic [RETRY_W-1:0] retry;
  logic [CNT_W-1:0]   dly_cnt;
  logic [15:0]        word;

  logic               is_end;
  logic               is_dly;
  logic               is_last;
  logic [CNT_W-1:0]   dly_load;

  // Classify the latched ROM word and precompute the end-of-table test.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can leave
    // it unassigned and infer a latch.
    is_end   = 1'b0;
    is_dly   = 1'b0;
    is_last  = 1'b0;
    dly_load = '0;
    is_end   = (word == 16'hFFFF);
    is_dly   = (word[7:0] == 8'hFF);
    is_last  = (({1'b0, idx} + (ADDR_W + 1)'(1)) == REGS_W);
    dly_load = CNT_W'(word[15:8]) * CNT_W'(DELAY_UNIT);
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous and clears datapath registers as well as
    // state, so every output reads 0 on the edge after rst_n is sampled low.
    if (!rst_n) begin
      state     <= S_IDLE;
      idx       <= '0;
      retry     <= '0;
      dly_cnt   <= '0;
      word      <= '0;
      rom_addr  <= '0;
      cmd_valid <= 1'b0;
      cmd_reg   <= '0;
      cmd_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      err_idx   <= '0;
    end else begin
      // NOTE: all state here is updated with non-blocking assignments so each
      // register sees the pre-edge value of every other register.
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            state    <= S_FETCH;
            idx      <= '0;
            rom_addr <= '0;
            retry    <= '0;
            busy     <= 1'b1;
            done     <= 1'b0;
            error    <= 1'b0;
            err_idx  <= '0;
          end
        end

        // rom_addr was already set to idx on entry; the ROM registers it now.
        S_FETCH: begin
          rom_addr <= idx;
          state    <= S_LATCH;
        end

        S_LATCH: begin
          word  <= rom_data;
          state <= S_DECODE;
        end

        S_DECODE: begin
          if (is_end) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (is_dly) begin
            if (word[15:8] == 8'd0) begin
              state <= S_NEXT;
            end else begin
              dly_cnt <= dly_load;
              state   <= S_DELAY;
            end
          end else begin
            cmd_reg   <= word[7:0];
            cmd_data  <= word[15:8];
            cmd_valid <= 1'b1;
            state     <= S_ISSUE;
          end
        end

        // Command fields stay frozen until the master takes the command.
        S_ISSUE: begin
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            state     <= S_WAIT_RESP;
          end
        end

        S_WAIT_RESP: begin
          if (cmd_done) begin
            if (!cmd_nack) begin
              retry <= '0;
`ifdef OV_SOFTRST_WAIT_EN
              if (cmd_reg == 8'h12 && cmd_data[7]) begin
                dly_cnt <= CNT_W'(RST_WAIT_CYC);
                state   <= S_DELAY;
              end else begin
                state <= S_NEXT;
              end
`else
              state <= S_NEXT;
`endif
            end else if (retry < RETRY_W'(MAX_RETRY)) begin
              retry     <= retry + RETRY_W'(1);
              cmd_valid <= 1'b1;
              state     <= S_ISSUE;
            end else begin
              err_idx <= idx;
              busy    <= 1'b0;
              error   <= 1'b1;
              state   <= S_ERROR;
            end
          end
        end

        // A load of N spends exactly N cycles here.
        S_DELAY: begin
          if (dly_cnt <= CNT_W'(1)) begin
            state <= S_NEXT;
          end else begin
            dly_cnt <= dly_cnt - CNT_W'(1);
          end
        end

        S_NEXT: begin
          idx <= idx + ADDR_W'(1);
          if (is_last) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            rom_addr <= idx + ADDR_W'(1);
            state    <= S_FETCH;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ov7670_cfg_seq.sv
// Self-checking bench for ov7670_cfg_seq: ROM model, SCCB master model with a
// command scoreboard, a table of whole-sequence scenarios and hand-written
// timing, stall and reset sequences.
module tb_ov7670_cfg_seq;

  localparam int ADDR_W       = 5;
  localparam int NUM_REGS     = 23;
  localparam int DELAY_UNIT   = 4;
  localparam int MAX_RETRY    = 3;
  localparam int RST_WAIT_CYC = 50;
  localparam int BUDGET       = 3000;
  localparam int RESP_LAT     = 10;

`ifdef OV_SOFTRST_WAIT_EN
  localparam int GAP_SOFTRST = 5 + RST_WAIT_CYC;
`else
  localparam int GAP_SOFTRST = 5;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              cmd_ready = 1'b0;
  logic              cmd_done = 1'b0;
  logic              cmd_nack = 1'b0;
  logic [15:0]       rom_data;
  logic [ADDR_W-1:0] rom_addr;
  logic [ADDR_W-1:0] err_idx;
  logic              cmd_valid;
  logic              busy;
  logic              done;
  logic              error;
  logic [7:0]        cmd_reg;
  logic [7:0]        cmd_data;

  ov7670_cfg_seq #(
    .ADDR_W      (ADDR_W),
    .NUM_REGS    (NUM_REGS),
    .DELAY_UNIT  (DELAY_UNIT),
    .MAX_RETRY   (MAX_RETRY),
    .RST_WAIT_CYC(RST_WAIT_CYC)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_reg  (cmd_reg),
    .cmd_data (cmd_data),
    .cmd_done (cmd_done),
    .cmd_nack (cmd_nack),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .err_idx  (err_idx)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous ROM: data valid one cycle after the address.
  logic [15:0] rom [0:31];
  always @(posedge clk) rom_data <= rom[rom_addr];

  // Scoreboard and master-model state.
  logic [15:0] exp_q[$];
  int          rise_cyc[$];
  int          done_cyc[$];
  int          n_acc = 0;
  int          resp_cnt = 0;
  logic [8:0]  nack_reg = 9'h100;
  logic [7:0]  pend_reg = 8'h00;
  logic        prev_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] base_word(input int i);
    logic [7:0] v;
    logic [7:0] r;
    v = 8'(i * 5 + 1);
    r = 8'(8'h40 + i);
    if (i == 0) return 16'h8012;
    if (i == NUM_REGS - 1) return 16'h403D;
    return {v, r};
  endfunction

  // SCCB master model: runs just after each falling edge so it sees the
  // inputs the main sequence drove on that edge. Accepts pop the scoreboard;
  // cmd_done follows RESP_LAT cycles after each accept.
  initial begin
    logic [15:0] e;
    forever begin
      @(negedge clk);
      #1;
      cmd_done = 1'b0;
      cmd_nack = 1'b0;
      if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) begin
          cmd_done = 1'b1;
          cmd_nack = ({1'b0, pend_reg} == nack_reg);
          done_cyc.push_back(cyc);
        end
      end
      if (cmd_valid && !prev_valid) rise_cyc.push_back(cyc);
      prev_valid = cmd_valid;
      if (rst_n && cmd_valid && cmd_ready) begin
        e = 16'hxxxx;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        check($sformatf("cmd_word_%0d", n_acc), {16'h0, cmd_data, cmd_reg}, {16'h0, e});
        n_acc++;
        pend_reg = cmd_reg;
        resp_cnt = RESP_LAT;
      end
    end
  end

  // Fill the ROM for one scenario and push the commands it should produce.
  task automatic load_rom(input int end_at, input int dly_at, input logic [7:0] dly_val,
                          input int nack_at);
    exp_q.delete();
    rise_cyc.delete();
    done_cyc.delete();
    n_acc    = 0;
    nack_reg = 9'h100;
    for (int i = 0; i < 32; i++) rom[i] = base_word(i);
    if (dly_at >= 0) rom[dly_at] = {dly_val, 8'hFF};
    if (end_at >= 0) rom[end_at] = 16'hFFFF;
    if (nack_at >= 0) nack_reg = {1'b0, rom[nack_at][7:0]};
    for (int i = 0; i < NUM_REGS; i++) begin
      if (i == end_at) break;
      if (i == dly_at) continue;
      if (i == nack_at) begin
        for (int r = 0; r <= MAX_RETRY; r++) exp_q.push_back(rom[i]);
        break;
      end
      exp_q.push_back(rom[i]);
    end
  endtask

  // start high for exactly one rising edge; returns on the following falling edge.
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_finish(input string name);
    int n = 0;
    while (!(done || error) && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check({name, "_finished"}, {31'h0, done | error}, 32'd1);
  endtask

  function automatic int gap(input int rise_i, input int done_i);
    if (rise_cyc.size() > rise_i && done_cyc.size() > done_i)
      return rise_cyc[rise_i] - done_cyc[done_i];
    return -1;
  endfunction

  typedef struct packed {
    int         end_at;
    int         dly_at;
    logic [7:0] dly_val;
    int         nack_at;
    int         exp_cmds;
    logic       exp_done;
    logic       exp_error;
    logic [4:0] exp_err_idx;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int         n;
    logic       stable;
    logic [7:0] r0;
    logic [7:0] d0;
    string      nm;

    vecs[0] = '{-1, -1, 8'd0, -1, 23, 1'b1, 1'b0, 5'd0};   // full table
    vecs[1] = '{ 3, -1, 8'd0, -1,  3, 1'b1, 1'b0, 5'd0};   // end marker at 3
    vecs[2] = '{-1,  5, 8'd3, -1, 22, 1'b1, 1'b0, 5'd0};   // delay marker
    vecs[3] = '{-1,  5, 8'd0, -1, 22, 1'b1, 1'b0, 5'd0};   // zero delay marker
    vecs[4] = '{-1, -1, 8'd0,  7, 11, 1'b0, 1'b1, 5'd7};   // NACK at entry 7
    vecs[5] = '{-1, -1, 8'd0, -1, 23, 1'b1, 1'b0, 5'd0};   // rerun after error
    vecs[6] = '{ 0, -1, 8'd0, -1,  0, 1'b1, 1'b0, 5'd0};   // end marker first
    vecs[7] = '{-1, -1, 8'd0, 22, 26, 1'b0, 1'b1, 5'd22};  // NACK at last entry

    // Reset state and no automatic start.
    load_rom(3, -1, 8'd0, -1);
    rst_n     = 1'b0;
    cmd_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_cmd_valid", {31'h0, cmd_valid}, 32'd0);
    check("rst_busy", {31'h0, busy}, 32'd0);
    check("rst_done", {31'h0, done}, 32'd0);
    check("rst_error", {31'h0, error}, 32'd0);
    check("rst_err_idx", {27'h0, err_idx}, 32'd0);
    check("rst_rom_addr", {27'h0, rom_addr}, 32'd0);
    check("rst_cmd_reg_data", {16'h0, cmd_data, cmd_reg}, 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("no_auto_start", {31'h0, busy}, 32'd0);

    // Start-to-first-command latency, one-cycle valid with ready high.
    pulse_start();
    check("c1_busy", {31'h0, busy}, 32'd1);
    check("c1_rom_addr", {27'h0, rom_addr}, 32'd0);
    check("c1_cmd_valid", {31'h0, cmd_valid}, 32'd0);
    @(negedge clk);
    check("c2_cmd_valid", {31'h0, cmd_valid}, 32'd0);
    @(negedge clk);
    check("c3_cmd_valid", {31'h0, cmd_valid}, 32'd0);
    @(negedge clk);
    check("c4_cmd_valid", {31'h0, cmd_valid}, 32'd1);
    check("c4_first_cmd", {16'h0, cmd_data, cmd_reg}, 32'h8012);
    @(negedge clk);
    check("c5_valid_dropped", {31'h0, cmd_valid}, 32'd0);
    wait_finish("timing");
    check("timing_n_acc", n_acc, 32'd3);
    check("timing_done", {31'h0, done}, 32'd1);

    // Entry-to-entry overhead, delay marker length, soft-reset settle.
    load_rom(-1, 5, 8'd3, -1);
    pulse_start();
    wait_finish("gap");
    check("gap_softrst", gap(1, 0), GAP_SOFTRST);
    check("gap_normal", gap(2, 1), 32'd5);
    check("gap_delay12", gap(5, 4), 32'd5 + 32'd4 + 32'd3 * DELAY_UNIT);

    load_rom(-1, 5, 8'd0, -1);
    pulse_start();
    wait_finish("gap0");
    check("gap_delay0", gap(5, 4), 32'd9);

    // Ready held low: command must stay frozen; mid-sequence start ignored.
    load_rom(4, -1, 8'd0, -1);
    cmd_ready = 1'b0;
    pulse_start();
    n = 0;
    while (!cmd_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("stall_valid_seen", {31'h0, cmd_valid}, 32'd1);
    r0 = cmd_reg;
    d0 = cmd_data;
    check("stall_first_cmd", {16'h0, d0, r0}, 32'h8012);
    stable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      start = (i == 2);
      stable = stable & cmd_valid & (cmd_reg == r0) & (cmd_data == d0);
    end
    start = 1'b0;
    check("stall_stable", {31'h0, stable}, 32'd1);
    cmd_ready = 1'b1;
    @(negedge clk);
    check("stall_valid_dropped", {31'h0, cmd_valid}, 32'd0);
    wait_finish("stall");
    check("stall_n_acc", n_acc, 32'd4);
    check("stall_q_empty", exp_q.size(), 32'd0);

    // Reset in the middle of a command.
    load_rom(-1, -1, 8'd0, -1);
    pulse_start();
    n = 0;
    while (!(n_acc >= 2 && cmd_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("midrst_reached", {31'h0, cmd_valid}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_outputs", {cmd_valid, busy, done, error, 3'b0, rom_addr, err_idx,
                             cmd_reg, cmd_data}, 32'd0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("midrst_stays_idle", {30'h0, busy, cmd_valid}, 32'd0);
    check("midrst_no_cmds", n_acc, 32'd2);

    // Table of whole-sequence scenarios.
    for (int k = 0; k < 8; k++) begin
      nm = $sformatf("v%0d", k);
      load_rom(vecs[k].end_at, vecs[k].dly_at, vecs[k].dly_val, vecs[k].nack_at);
      pulse_start();
      check({nm, "_busy_on_start"}, {31'h0, busy}, 32'd1);
      check({nm, "_cleared_on_start"}, {29'h0, done, error, |err_idx}, 32'd0);
      wait_finish(nm);
      check({nm, "_n_cmds"}, n_acc, vecs[k].exp_cmds);
      check({nm, "_q_empty"}, exp_q.size(), 32'd0);
      check({nm, "_status"}, {29'h0, busy, done, error},
            {29'h0, 1'b0, vecs[k].exp_done, vecs[k].exp_error});
      check({nm, "_err_idx"}, {27'h0, err_idx}, {27'h0, vecs[k].exp_err_idx});
      repeat (3) @(negedge clk);
      check({nm, "_status_held"}, {30'h0, done, error},
            {30'h0, vecs[k].exp_done, vecs[k].exp_error});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, n_tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ov7670_cfg_seq.md
# ov7670_cfg_seq

Parametrised OV7670 configuration sequencer that walks a synchronous register ROM of `{value, reg_addr}` words and issues each entry as an SCCB write command to the SCCB master. It sits between the camera register table and the SCCB master in the MJPEG capture front end. It adds the following:
- Start and restart control.
- Table-end and delay marker entries.
- NACK retry with error reporting.
- Busy and done status for the capture pipeline.

## Interface
Parameters:
- `ADDR_W`, 5: ROM address width.
- `NUM_REGS`, 23: number of table entries walked; must be ≤ 2^ADDR_W.
- `DELAY_UNIT`, 1000: clk cycles per delay-marker tick.
- `MAX_RETRY`, 3: retries per entry after a NACK.
- `RST_WAIT_CYC`, 100000: wait after a soft-reset write (macro-gated).

Ports. One clock; reset is synchronous and active-low. All ports are registered except `rom_data`.
- `clk` in 1: system clock.
- `rst_n` in 1: synchronous active-low reset.
- `start` in 1: single-cycle request to begin or restart the sequence.
- `rom_addr` out ADDR_W: ROM address.
- `rom_data` in 16: ROM word; valid 1 cycle after `rom_addr`. Bits [15:8] are the value, bits [7:0] the register.
- `cmd_valid` out 1: write command valid.
- `cmd_ready` in 1: master accepts the command when `cmd_valid && cmd_ready`.
- `cmd_reg` out 8: register address.
- `cmd_data` out 8: register value.
- `cmd_done` in 1: single-cycle completion pulse from the master.
- `cmd_nack` in 1: sampled with `cmd_done`; 1 means the slave NACKed.
- `busy` out 1: high from accepted start until DONE or ERROR.
- `done` out 1: level; high when the sequence completes successfully.
- `error` out 1: level; high when retries are exhausted.
- `err_idx` out ADDR_W: index of the failing entry.

## Operation
- Reset value of every output is 0. The FSM enters IDLE and the index counter clears to 0.
- States and transitions:
  - IDLE: on `start`, go to FETCH.
  - FETCH: drive `rom_addr` = idx.
  - LATCH: capture `rom_data` one cycle after FETCH.
  - DECODE: classify the captured word.
  - ISSUE: hold `cmd_valid` until the handshake, then go to WAIT_RESP.
  - WAIT_RESP: wait for `cmd_done`.
  - DELAY: count down, then go to NEXT.
  - NEXT: idx+1. Go to DONE if idx+1 == NUM_REGS, else FETCH.
  - DONE and ERROR: hold until `start` or reset.
- DECODE rules:
  - Word 16'hFFFF: end marker; go straight to DONE.
  - Register byte 8'hFF with any other value: delay marker. Load the counter with value×DELAY_UNIT and go to DELAY; a value of 0 means no wait, go straight to NEXT.
  - Any other word: go to ISSUE with `cmd_reg` = [7:0], `cmd_data` = [15:8].
- `cmd_reg` and `cmd_data` are stable from `cmd_valid` rising until the handshake. `cmd_valid` drops the cycle after the handshake.
- In WAIT_RESP, on `cmd_done`:
  - NACK = 0: go to NEXT and clear the retry counter.
  - NACK = 1 and retries < MAX_RETRY: increment retries and re-enter ISSUE with the same entry.
  - Otherwise: go to ERROR, set `err_idx` = idx.
- `cmd_done` outside WAIT_RESP is ignored.
- `start` in IDLE, DONE or ERROR restarts from idx 0. This clears `done`, `error`, `err_idx` and the retry counter, and sets `busy` the next cycle.
- `start` while `busy` is ignored.
- `rst_n` low in any state aborts immediately; `cmd_valid` goes low on the next edge. The sequencer waits for `start` again and performs no automatic start.
- The delay counter is wide enough for 255×DELAY_UNIT (or RST_WAIT_CYC if larger) without wrap.

## Timing
- `start` at cycle 0:
  - `busy` = 1 at cycle 1.
  - `rom_addr` = 0 at cycle 1.
  - Data latched at cycle 2.
  - `cmd_valid` = 1 at cycle 4 at the earliest.
- Entry-to-entry overhead is 4 clk after `cmd_done`: NEXT, FETCH, LATCH, DECODE before ISSUE.
- DONE or ERROR:
  - `busy` falls and `done`/`error` rises in the same cycle.
  - Both levels hold until the next `start` or reset.
- A DELAY of N cycles occupies exactly N cycles in DELAY before NEXT.
- With `cmd_ready` tied high, `cmd_valid` is high for exactly 1 cycle per attempt.

## Configuration
- `OV_SOFTRST_WAIT_EN` defined: after a successful write of register 8'h12 with value bit 7 set, go to DELAY with RST_WAIT_CYC instead of NEXT. This inserts the mandatory post-COM7 reset settle time.
- Undefined: that write proceeds directly to NEXT. Any settle time must then come from a delay marker in the table.

## Test plan
- 23-entry table, `cmd_ready` = 1, `cmd_done` 10 cycles after each accept, NACK = 0 → 23 commands in ROM order, first (`cmd_reg` 8'h12, `cmd_data` 8'h80), last (8'h3D, 8'h40). Then `done` = 1, `busy` = 0.
- Entry 5 = 16'h03FF with DELAY_UNIT = 4 → exactly 12 idle cycles with no `cmd_valid` between the entry-4 `cmd_done` path and the entry-6 fetch. Entry 5 issues no command.
- Entry 3 = 16'hFFFF → only entries 0–2 issued, then `done` = 1.
- NACK on every attempt at entry 7, MAX_RETRY = 3 → 4 attempts at entry 7, then `error` = 1, `err_idx` = 7, `busy` = 0. A following `start` reruns from entry 0 with `error` cleared.
- `cmd_ready` low for 6 cycles → `cmd_valid`, `cmd_reg` and `cmd_data` stay stable throughout. `start` pulsed mid-sequence is ignored. `rst_n` low mid-command → all outputs 0 next edge, sequencer stays IDLE.
- `OV_SOFTRST_WAIT_EN` defined, RST_WAIT_CYC = 50 → 50-cycle gap after the entry-0 `cmd_done` before the entry-1 fetch. Undefined → the normal 4-cycle gap.
